// File: rtl/rx_bit_sampler.sv
// Oversampling front end of the UART receiver: synchronises the serial line, tracks the
// edge/bit position inside a frame and produces a 3-sample majority vote at mid-bit.
module rx_bit_sampler #(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  smp_en,
  output logic                  sampled_bit,
  output logic                  smp_valid,
  output logic                  bit_done,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]  bit_cnt
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state, state_nxt;
  logic                    rx_meta, rx_s;
  logic [PRESCALE_W-1:0]   ps, ps_nxt;
  logic [PRESCALE_W-1:0]   half, vote_early, vote_late, last_edge;
  logic [PRESCALE_W-1:0]   edge_nxt;
  logic [BIT_CNT_W-1:0]    bit_nxt;
  logic                    s0, s1, s0_nxt, s1_nxt;
  logic                    sampled_nxt, valid_nxt, done_nxt;

  function automatic logic maj(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= RX_IN;
      rx_s    <= rx_meta;
    end
  end

  assign half       = ps >> 1;
  assign vote_early = half - PRESCALE_W'(1);
  assign vote_late  = half + PRESCALE_W'(1);
  assign last_edge  = ps - PRESCALE_W'(1);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE:    if (smp_en)  state_nxt = RUN;
      RUN:     if (!smp_en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values for the registered outputs, counters and vote samples.
  always_comb begin
    ps_nxt      = ps;
    edge_nxt    = edge_cnt;
    bit_nxt     = bit_cnt;
    s0_nxt      = s0;
    s1_nxt      = s1;
    sampled_nxt = sampled_bit;
    valid_nxt   = 1'b0;
    done_nxt    = 1'b0;
    case (state)
      IDLE: begin
        edge_nxt = '0;
        bit_nxt  = '0;
        if (smp_en) ps_nxt = Prescale;
      end
      RUN: begin
        if (!smp_en) begin
          // Leaving the frame beats any vote or wrap on the same edge.
          edge_nxt = '0;
          bit_nxt  = '0;
        end else begin
          if (edge_cnt == last_edge) begin
            edge_nxt = '0;
            done_nxt = 1'b1;
            if (bit_cnt != {BIT_CNT_W{1'b1}}) bit_nxt = bit_cnt + BIT_CNT_W'(1);
          end else begin
            edge_nxt = edge_cnt + PRESCALE_W'(1);
          end
          if (edge_cnt == vote_early) s0_nxt = rx_s;
          if (edge_cnt == half)       s1_nxt = rx_s;
          if (edge_cnt == vote_late) begin
            sampled_nxt = maj(s0, s1, rx_s);
            valid_nxt   = 1'b1;
          end
        end
      end
      default: begin
        edge_nxt = '0;
        bit_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ps          <= PRESCALE_W'(8);
      edge_cnt    <= '0;
      bit_cnt     <= '0;
      s0          <= 1'b1;
      s1          <= 1'b1;
      sampled_bit <= 1'b1;
      smp_valid   <= 1'b0;
      bit_done    <= 1'b0;
    end else begin
      ps          <= ps_nxt;
      edge_cnt    <= edge_nxt;
      bit_cnt     <= bit_nxt;
      s0          <= s0_nxt;
      s1          <= s1_nxt;
      sampled_bit <= sampled_nxt;
      smp_valid   <= valid_nxt;
      bit_done    <= done_nxt;
    end
  end

endmodule

// File: tb/tb_rx_bit_sampler.sv
// Directed bench for rx_bit_sampler: idle, clean byte, glitch vote, frozen prescale,
// async reset, smp_en drop on the vote edge and bit_cnt saturation.
module tb_rx_bit_sampler;
  localparam int PW = 6;
  localparam int BW = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic          RX_IN;
  logic [PW-1:0] Prescale;
  logic          smp_en;
  logic          sampled_bit, smp_valid, bit_done;
  logic [PW-1:0] edge_cnt;
  logic [BW-1:0] bit_cnt;

  int errors = 0;
  int checks = 0;

  rx_bit_sampler #(.PRESCALE_W(PW), .BIT_CNT_W(BW)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale), .smp_en(smp_en),
    .sampled_bit(sampled_bit), .smp_valid(smp_valid), .bit_done(bit_done),
    .edge_cnt(edge_cnt), .bit_cnt(bit_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Compares all outputs except sampled_bit against expected values.
  task automatic expect_state(input string tag, input int e_edge, input int e_bit,
                              input logic e_valid, input logic e_done);
    checks++;
    if (edge_cnt !== PW'(e_edge)) begin
      errors++; $display("FAIL %s edge_cnt got %0d exp %0d", tag, edge_cnt, e_edge);
    end
    checks++;
    if (bit_cnt !== BW'(e_bit)) begin
      errors++; $display("FAIL %s bit_cnt got %0d exp %0d", tag, bit_cnt, e_bit);
    end
    checks++;
    if (smp_valid !== e_valid) begin
      errors++; $display("FAIL %s smp_valid got %b exp %b", tag, smp_valid, e_valid);
    end
    checks++;
    if (bit_done !== e_done) begin
      errors++; $display("FAIL %s bit_done got %b exp %b", tag, bit_done, e_done);
    end
  endtask

  // Drives one bit period. mask[k] inverts rx_s at edge k (the pin leads rx_s by 2 CLK).
  task automatic run_bit(input string tag, input int b, input int ps, input logic val,
                         input logic [63:0] mask);
    int   m;
    int   exp_bc;
    logic exp_vote;
    m        = ps / 2;
    exp_bc   = (b > 15) ? 15 : b;
    exp_vote = ((val ^ mask[m-1]) & (val ^ mask[m])) | ((val ^ mask[m-1]) & (val ^ mask[m+1])) |
               ((val ^ mask[m]) & (val ^ mask[m+1]));
    for (int e = 0; e < ps; e++) begin
      RX_IN = (e + 2 < ps) ? (val ^ mask[e+2]) : val;
      expect_state($sformatf("%s b%0d e%0d", tag, b, e), e, exp_bc, (e == m + 2), (e == 0 && b > 0));
      if (e == m + 2) begin
        checks++;
        if (sampled_bit !== exp_vote) begin
          errors++;
          $display("FAIL %s b%0d sampled_bit got %b exp %b", tag, b, sampled_bit, exp_vote);
        end
      end
      tick();
    end
  endtask

  task automatic start_frame(input int ps);
    Prescale = PW'(ps);
    RX_IN    = 1'b1;
    smp_en   = 1'b1;
    tick();
  endtask

  task automatic end_frame(input string tag);
    smp_en = 1'b0;
    RX_IN  = 1'b1;
    tick();
    expect_state({tag, " end"}, 0, 0, 1'b0, 1'b0);
    repeat (3) tick();
  endtask

  task automatic test_reset;
    RST = 1'b0; RX_IN = 1'b1; smp_en = 1'b0; Prescale = PW'(8);
    repeat (3) tick();
    expect_state("reset held", 0, 0, 1'b0, 1'b0);
    RST = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (i % 10 == 9) begin
        expect_state($sformatf("idle c%0d", i), 0, 0, 1'b0, 1'b0);
        checks++;
        if (sampled_bit !== 1'b1) begin
          errors++; $display("FAIL idle sampled_bit got %b exp 1", sampled_bit);
        end
      end
    end
  endtask

  task automatic test_clean_byte;
    logic [9:0] frame;
    frame = {1'b1, 8'hA5, 1'b0};
    start_frame(8);
    for (int b = 0; b < 10; b++) run_bit("clean", b, 8, frame[b], 64'd0);
    end_frame("clean");
  endtask

  task automatic test_glitch;
    start_frame(16);
    run_bit("glitch", 0, 16, 1'b0, 64'd0);
    run_bit("glitch", 1, 16, 1'b1, 64'h80);
    run_bit("glitch", 2, 16, 1'b1, 64'h180);
    run_bit("glitch", 3, 16, 1'b0, 64'h80);
    end_frame("glitch");
  endtask

  task automatic test_prescale_frozen;
    start_frame(8);
    for (int b = 0; b < 6; b++) begin
      if (b == 3) Prescale = PW'(16);
      run_bit("frozen", b, 8, logic'(b % 2), 64'd0);
    end
    end_frame("frozen");
    Prescale = PW'(8);
  endtask

  task automatic test_async_reset;
    start_frame(8);
    for (int b = 0; b < 4; b++) run_bit("arst", b, 8, 1'b0, 64'd0);
    RX_IN = 1'b0;
    repeat (5) tick();
    expect_state("arst pre", 5, 4, 1'b0, 1'b0);
    checks++;
    if (sampled_bit !== 1'b0) begin
      errors++; $display("FAIL arst pre sampled_bit got %b exp 0", sampled_bit);
    end
    RST = 1'b0;
    #1;
    expect_state("arst low", 0, 0, 1'b0, 1'b0);
    checks++;
    if (sampled_bit !== 1'b1) begin
      errors++; $display("FAIL arst low sampled_bit got %b exp 1", sampled_bit);
    end
    #2;
    RST = 1'b1;
    RX_IN = 1'b1;
    tick();
    expect_state("arst restart e0", 0, 0, 1'b0, 1'b0);
    tick();
    expect_state("arst restart e1", 1, 0, 1'b0, 1'b0);
    end_frame("arst");
  endtask

  task automatic test_drop_on_vote;
    start_frame(8);
    run_bit("drop", 0, 8, 1'b1, 64'd0);
    RX_IN = 1'b0;
    repeat (5) tick();
    expect_state("drop vote edge", 5, 1, 1'b0, 1'b0);
    smp_en = 1'b0;
    tick();
    expect_state("drop after", 0, 0, 1'b0, 1'b0);
    checks++;
    if (sampled_bit !== 1'b1) begin
      errors++; $display("FAIL drop sampled_bit got %b exp 1", sampled_bit);
    end
    smp_en = 1'b1;
    RX_IN  = 1'b1;
    tick();
    expect_state("drop rerise e0", 0, 0, 1'b0, 1'b0);
    tick();
    expect_state("drop rerise e1", 1, 0, 1'b0, 1'b0);
    end_frame("drop");
  endtask

  task automatic test_back_to_back_long;
    start_frame(8);
    for (int b = 0; b < 20; b++) run_bit("long", b, 8, logic'((b / 3) % 2), 64'd0);
    end_frame("long");
  endtask

  initial begin
    test_reset();
    test_clean_byte();
    test_glitch();
    test_prescale_frozen();
    test_async_reset();
    test_drop_on_vote();
    test_back_to_back_long();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
